psum_bank_buf: RTL and testbench
================================

Name: psum_bank_buf

Overview:
- Parametrised N-bank partial-sum buffer, the successor to the two-bank, chip-select psum arrangement in the core.
- One bank is the "fill" bank: it receives SFP results and serves psum feedback reads. Full banks queue up and are drained autonomously through a valid/ready output stream.
- A swap command rotates banks in ring order, replacing manual chip_sel and out_en sequencing.

Parameters:
PSUM_BW, 16, bits per psum element
COL, 8, elements per row; row width W = COL*PSUM_BW
NUM_BANK, 2, number of banks (>=2)
DEPTH, 2048, rows per bank
AW, $clog2(DEPTH), address width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write row into fill bank
wr_addr  in  AW  write address
wr_data  in  W  write data
wr_acc  in  1  accumulate-write (only with PSUM_ACC_EN)
rd_en  in  1  feedback read from fill bank
rd_addr  in  AW  read address
rd_data  out  W  read data, valid 1 cycle after rd_en
swap  in  1  close fill bank, advance to next bank
swap_ready  out  1  a free bank exists; swap accepted this cycle
fill_bank  out  $clog2(NUM_BANK)  current fill bank index
out_valid  out  1  drain beat valid
out_ready  in  1  downstream accepts beat
out_data  out  W  drain row data
out_last  out  1  final row of current bank
out_bank  out  $clog2(NUM_BANK)  bank being drained
busy  out  1  at least one bank pending or draining

Behaviour:
- Reset values (asynchronous, on reset==0):
  - fill_ptr=0, drain_ptr=0, pending=0, all length registers 0, high-water mark (hwm)=0, FSM=IDLE.
  - rd_data=0, out_valid=0, out_data=0, out_last=0, busy=0, swap_ready=1.
  - Memory contents are NOT cleared.
- Storage: one synchronous-read, DEPTH x W array per bank, behavioural.
- Fill side:
  - wr_en writes the fill bank at the clock edge.
  - hwm tracks max(wr_addr)+1 over the current fill session.
  - rd_en returns fill-bank data on rd_data the next cycle.
  - Read and write to the same address in the same cycle: rd_data returns the OLD value.
  - rd_data holds its value when rd_en=0.
- Swap:
  - swap_ready = (pending < NUM_BANK-1).
  - When swap && swap_ready:
    - len[fill_ptr] <= hwm, counting a write in the same cycle (that write lands in the closing bank).
    - fill_ptr advances modulo NUM_BANK.
    - hwm <= 0.
    - pending increments.
  - swap while !swap_ready is ignored and has no side effects.
- Drain FSM, states IDLE -> LOAD -> STREAM -> IDLE:
  - IDLE: if pending>0, latch drain_ptr and its len into the row counter, then go to LOAD.
  - LOAD, len==0: release the bank immediately (pending--, drain_ptr++) and emit no beats.
  - LOAD, len>0: issue a read of row 0, go to STREAM.
  - STREAM:
    - A 2-entry output skid buffer plus an in-flight read gives 1 beat/cycle while out_ready=1.
    - A new read is issued only if the skid buffer has room counting the in-flight read.
    - out_data and out_valid hold stable while out_valid && !out_ready.
    - out_last=1 on row len-1.
    - When the last beat is accepted: pending--, drain_ptr++ modulo NUM_BANK, return to IDLE.
  - Back-to-back pending banks: IDLE->LOAD costs at most 2 bubble cycles between banks.
- Same-cycle swap and drain completion: pending is unchanged (+1 -1).
- busy = (pending!=0) || (FSM!=IDLE).
- Fill/drain overlap: the fill bank is never the drain bank. This is guaranteed by the swap_ready rule.
- Reset mid-drain: the stream aborts, out_valid drops asynchronously, and no partial bank is resumed.

Optional Feature:
PSUM_ACC_EN:
- Defined:
  - wr_en && wr_acc performs a read-modify-write: stored row += wr_data, per element, PSUM_BW two's-complement with wrap-around.
  - The write commits 1 cycle later.
  - Back-to-back accumulates to the same address forward the pending result, with no lost updates.
  - hwm updates at issue.
  - A swap in the same cycle as an outstanding RMW commits the RMW into the closing bank before it can be drained.
- Undefined: wr_acc is ignored; every write is a plain overwrite.

Test Plan:
- Write rows 0..7 with value 0x0101*(addr+1) per element, swap, out_ready=1 -> 8 consecutive beats, data matches, out_last on beat 7, out_bank=0, then busy=0.
- NUM_BANK=2, swap twice without draining (out_ready=0) -> second swap ignored with swap_ready=0, fill_bank stays 1. Raise out_ready -> bank 0 drains, swap_ready returns 1.
- Drain with out_ready toggling 1,0,0,1,... -> no duplicated or dropped rows, out_data stable while stalled.
- Swap with no writes -> zero beats, pending returns to 0 within 3 cycles.
- Assert reset (0) mid-drain at beat 3 of 8 -> out_valid=0 immediately. After release, busy=0, fill_bank=0, swap_ready=1.
- PSUM_ACC_EN: write addr 5 = 10 per element, then three back-to-back wr_acc of +1 to addr 5, swap, drain -> row 5 = 13 per element. Element 0x7FFF + 1 -> 0x8000.

Source files
------------

// File: rtl/psum_bank_buf.sv
// psum_bank_buf: N-bank partial-sum buffer, ring-order swap, autonomous drain.
// Build option: define PSUM_ACC_EN for accumulate-writes (read-modify-write).
module psum_bank_buf #(
  parameter  int PSUM_BW  = 16,
  parameter  int COL      = 8,
  parameter  int NUM_BANK = 2,
  parameter  int DEPTH    = 2048,
  localparam int AW       = $clog2(DEPTH),
  localparam int W        = COL * PSUM_BW,
  localparam int BKW      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic           wr_acc,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
  output logic [W-1:0]   rd_data,
  input  logic           swap,
  output logic           swap_ready,
  output logic [BKW-1:0] fill_bank,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [BKW-1:0] out_bank,
  output logic           busy
);
  localparam int PW = $clog2(NUM_BANK + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} st_e;

  st_e            st_q, st_d;
  logic [W-1:0]   mem_q [NUM_BANK][DEPTH];
  logic [BKW-1:0] fill_ptr_q, drain_ptr_q;
  logic [PW-1:0]  pend_q;
  logic [AW:0]    hwm_q, hwm_d, wr_top;
  logic [AW:0]    len_q [NUM_BANK];
  logic [AW:0]    dlen_q, raddr_q;
  logic [W-1:0]   rd_data_q;
  logic [W-1:0]   sk_d0_q, sk_d1_q;
  logic           sk_l0_q, sk_l1_q;
  logic [1:0]     sk_cnt_q;
  logic           swap_ok, plain_wr;
  logic           issue, rel, pop;
  logic [W-1:0]   dr_row;
  logic           dr_last;

  function automatic logic [BKW-1:0] bk_inc(input logic [BKW-1:0] b);
    return (b == BKW'(NUM_BANK - 1)) ? '0 : b + BKW'(1);
  endfunction

  assign swap_ready = (pend_q < PW'(NUM_BANK - 1));
  assign swap_ok    = swap && swap_ready;
  assign wr_top     = {1'b0, wr_addr} + (AW+1)'(1);
  assign hwm_d      = (wr_en && (wr_top > hwm_q)) ? wr_top : hwm_q;

  assign out_valid  = (sk_cnt_q != 2'd0);
  assign out_data   = sk_d0_q;
  assign out_last   = out_valid && sk_l0_q;
  assign out_bank   = drain_ptr_q;
  assign fill_bank  = fill_ptr_q;
  assign rd_data    = rd_data_q;
  assign busy       = (pend_q != '0) || (st_q != IDLE);
  assign pop        = out_valid && out_ready;

  assign dr_row     = mem_q[drain_ptr_q][raddr_q[AW-1:0]];
  assign dr_last    = (raddr_q == dlen_q - (AW+1)'(1));

  always_comb begin
    st_d  = st_q;
    issue = 1'b0;
    rel   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (pend_q != '0) st_d = LOAD;
      end
      LOAD: begin
        if (dlen_q == '0) begin
          rel  = 1'b1;
          st_d = IDLE;
        end else begin
          issue = 1'b1;
          st_d  = STREAM;
        end
      end
      STREAM: begin
        // room is judged after this cycle's pop so a full-rate stream keeps going
        issue = (raddr_q != dlen_q) && !((sk_cnt_q == 2'd2) && !pop);
        if (pop && sk_l0_q) begin
          rel  = 1'b1;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= IDLE;
      fill_ptr_q  <= '0;
      drain_ptr_q <= '0;
      pend_q      <= '0;
      hwm_q       <= '0;
      dlen_q      <= '0;
      raddr_q     <= '0;
      rd_data_q   <= '0;
      for (int b = 0; b < NUM_BANK; b++) len_q[b] <= '0;
    end else begin
      st_q <= st_d;
      if (rd_en) rd_data_q <= mem_q[fill_ptr_q][rd_addr];
      if (swap_ok) begin
        len_q[fill_ptr_q] <= hwm_d;
        fill_ptr_q        <= bk_inc(fill_ptr_q);
        hwm_q             <= '0;
      end else begin
        hwm_q <= hwm_d;
      end
      unique case ({swap_ok, rel})
        2'b10:   pend_q <= pend_q + PW'(1);
        2'b01:   pend_q <= pend_q - PW'(1);
        default: pend_q <= pend_q;
      endcase
      if ((st_q == IDLE) && (pend_q != '0)) begin
        dlen_q  <= len_q[drain_ptr_q];
        raddr_q <= '0;
      end else if (issue) begin
        raddr_q <= raddr_q + (AW+1)'(1);
      end
      if (rel) drain_ptr_q <= bk_inc(drain_ptr_q);
    end
  end

  // two-entry skid buffer; the registered read lands straight into it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sk_d0_q  <= '0;
      sk_d1_q  <= '0;
      sk_l0_q  <= 1'b0;
      sk_l1_q  <= 1'b0;
      sk_cnt_q <= 2'd0;
    end else begin
      unique case ({issue, pop})
        2'b10: begin
          if (sk_cnt_q == 2'd0) begin
            sk_d0_q <= dr_row;
            sk_l0_q <= dr_last;
          end else begin
            sk_d1_q <= dr_row;
            sk_l1_q <= dr_last;
          end
          sk_cnt_q <= sk_cnt_q + 2'd1;
        end
        2'b01: begin
          sk_d0_q  <= sk_d1_q;
          sk_l0_q  <= sk_l1_q;
          sk_cnt_q <= sk_cnt_q - 2'd1;
        end
        2'b11: begin
          if (sk_cnt_q == 2'd1) begin
            sk_d0_q <= dr_row;
            sk_l0_q <= dr_last;
          end else begin
            sk_d0_q <= sk_d1_q;
            sk_l0_q <= sk_l1_q;
            sk_d1_q <= dr_row;
            sk_l1_q <= dr_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PSUM_ACC_EN
  logic           acc_v_q;
  logic [BKW-1:0] acc_bank_q;
  logic [AW-1:0]  acc_addr_q;
  logic [W-1:0]   acc_old_q, acc_add_q;
  logic [W-1:0]   acc_sum, acc_base;
  logic           acc_iss, acc_fwd;

  function automatic logic [W-1:0] vadd(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < COL; i++)
      s[i*PSUM_BW +: PSUM_BW] = a[i*PSUM_BW +: PSUM_BW]
                              + b[i*PSUM_BW +: PSUM_BW];
    return s;
  endfunction

  assign plain_wr = wr_en && !wr_acc;
  assign acc_iss  = wr_en && wr_acc;
  assign acc_sum  = vadd(acc_old_q, acc_add_q);
  // chained accumulates to one row pick up the uncommitted sum
  assign acc_fwd  = acc_v_q && (acc_bank_q == fill_ptr_q)
                  && (acc_addr_q == wr_addr);
  assign acc_base = acc_fwd ? acc_sum : mem_q[fill_ptr_q][wr_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_v_q    <= 1'b0;
      acc_bank_q <= '0;
      acc_addr_q <= '0;
      acc_old_q  <= '0;
      acc_add_q  <= '0;
    end else begin
      acc_v_q <= acc_iss;
      if (acc_iss) begin
        acc_bank_q <= fill_ptr_q;
        acc_addr_q <= wr_addr;
        acc_old_q  <= acc_base;
        acc_add_q  <= wr_data;
      end
    end
  end

  // a plain write issued after the RMW is younger and must win
  always_ff @(posedge clk) begin
    if (acc_v_q) mem_q[acc_bank_q][acc_addr_q] <= acc_sum;
    if (plain_wr) mem_q[fill_ptr_q][wr_addr] <= wr_data;
  end
`else
  logic unused_acc;
  assign unused_acc = wr_acc;
  assign plain_wr   = wr_en;

  always_ff @(posedge clk) begin
    if (plain_wr) mem_q[fill_ptr_q][wr_addr] <= wr_data;
  end
`endif

endmodule

// File: tb/tb_psum_bank_buf.sv
// tb_psum_bank_buf: directed vectors and drain sequences for psum_bank_buf.
// Expected rows are written as one 16-bit value replicated per element.
module tb_psum_bank_buf;
  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 2048;
  localparam int AW      = 11;
  localparam int W       = COL * PSUM_BW;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_acc;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          swap;
  logic          swap_ready;
  logic          fill_bank;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_bank;
  logic          busy;

  psum_bank_buf #(
    .PSUM_BW  (PSUM_BW),
    .COL      (COL),
    .NUM_BANK (2),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_acc     (wr_acc),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .swap       (swap),
    .swap_ready (swap_ready),
    .fill_bank  (fill_bank),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_bank   (out_bank),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exq[$];

  typedef struct {
    logic        we;
    int          wa;
    logic [15:0] wv;
    logic        re;
    int          ra;
    logic        sw;
    logic        crd;
    logic [15:0] erd;
    logic        esr;
    logic        efb;
    logic        ebusy;
    logic        eov;
    logic [15:0] eod;
  } vec_t;

  vec_t tv [9];

  function automatic logic [W-1:0] rowv(input logic [15:0] e);
    return {COL{e}};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] e,
                    input logic acc, input logic sw);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = rowv(e);
    wr_acc  = acc;
    swap    = sw;
    cyc();
    wr_en  = 1'b0;
    wr_acc = 1'b0;
    swap   = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_acc    = 1'b0;
    rd_en     = 1'b0;
    swap      = 1'b0;
    out_ready = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  task automatic drain(input string nm, input logic toggle, input logic eb);
    int   got, first, lastc;
    logic pv, pr;
    logic [W-1:0] pd;
    logic done;
    got = 0; first = -1; lastc = -1;
    pv = 1'b0; pr = 1'b0; pd = '0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      out_ready = toggle ? ((c % 3) == 0) : 1'b1;
      if (pv && !pr) begin
        chkb({nm, " stall valid"}, out_valid, 1'b1);
        chk({nm, " stall data"}, out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (got < exq.size())
          chk($sformatf("%s row%0d", nm, got), out_data, rowv(exq[got]));
        chkb($sformatf("%s last%0d", nm, got), out_last,
             got == exq.size() - 1);
        chkb({nm, " bank"}, out_bank, eb);
        if (first < 0) first = c;
        lastc = c;
        got++;
        done = out_last;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      cyc();
    end
    out_ready = 1'b0;
    chki({nm, " beats"}, got, exq.size());
    if (!toggle) chki({nm, " span"}, lastc - first + 1, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_acc    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    swap      = 1'b0;
    out_ready = 1'b0;

    tv[0] = '{1'b1, 0, 16'h0101, 1'b0, 0, 1'b0,
              1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[1] = '{1'b1, 1, 16'h0202, 1'b1, 0, 1'b0,
              1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[2] = '{1'b1, 1, 16'h0303, 1'b1, 1, 1'b0,
              1'b1, 16'h0202, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[3] = '{1'b0, 0, 16'h0000, 1'b0, 0, 1'b0,
              1'b1, 16'h0202, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[4] = '{1'b0, 0, 16'h0000, 1'b1, 1, 1'b0,
              1'b1, 16'h0303, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[5] = '{1'b1, 2, 16'h0404, 1'b0, 0, 1'b1,
              1'b1, 16'h0303, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tv[6] = '{1'b0, 0, 16'h0000, 1'b0, 0, 1'b1,
              1'b1, 16'h0303, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tv[7] = '{1'b1, 0, 16'h0909, 1'b0, 0, 1'b0,
              1'b1, 16'h0303, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0101};
    tv[8] = '{1'b0, 0, 16'h0000, 1'b1, 0, 1'b0,
              1'b1, 16'h0909, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0101};

    do_reset();
    chkb("rst out_valid", out_valid, 1'b0);
    chkb("rst busy", busy, 1'b0);
    chkb("rst swap_ready", swap_ready, 1'b1);
    chkb("rst fill_bank", fill_bank, 1'b0);
    chkb("rst out_last", out_last, 1'b0);
    chk("rst rd_data", rd_data, '0);
    chk("rst out_data", out_data, '0);

    for (int i = 0; i < 9; i++) begin
      wr_en   = tv[i].we;
      wr_addr = AW'(tv[i].wa);
      wr_data = rowv(tv[i].wv);
      rd_en   = tv[i].re;
      rd_addr = AW'(tv[i].ra);
      swap    = tv[i].sw;
      cyc();
      wr_en = 1'b0;
      rd_en = 1'b0;
      swap  = 1'b0;
      if (tv[i].crd)
        chk($sformatf("v%0d rd_data", i), rd_data, rowv(tv[i].erd));
      chkb($sformatf("v%0d swap_ready", i), swap_ready, tv[i].esr);
      chkb($sformatf("v%0d fill_bank", i), fill_bank, tv[i].efb);
      chkb($sformatf("v%0d busy", i), busy, tv[i].ebusy);
      chkb($sformatf("v%0d out_valid", i), out_valid, tv[i].eov);
      if (tv[i].eov)
        chk($sformatf("v%0d out_data", i), out_data, rowv(tv[i].eod));
    end

    exq = '{16'h0101, 16'h0303, 16'h0404};
    drain("toggle", 1'b1, 1'b0);
    chkb("toggle swap_ready", swap_ready, 1'b1);
    chkb("toggle fill_bank", fill_bank, 1'b1);
    chkb("toggle busy", busy, 1'b0);

    do_reset();
    exq.delete();
    for (int a = 0; a < 8; a++) begin
      wr(a, 16'(32'h0101 * (a + 1)), 1'b0, 1'b0);
      exq.push_back(16'(32'h0101 * (a + 1)));
    end
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    drain("seq", 1'b0, 1'b0);
    chkb("seq busy", busy, 1'b0);

    swap = 1'b1;
    cyc();
    swap = 1'b0;
    chkb("empty busy", busy, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chkb($sformatf("empty valid%0d", c), out_valid, 1'b0);
      cyc();
    end
    chkb("empty done busy", busy, 1'b0);
    chkb("empty swap_ready", swap_ready, 1'b1);
    chkb("empty fill_bank", fill_bank, 1'b0);

    for (int a = 0; a < 8; a++) wr(a, 16'(16'h1000 + a), 1'b0, 1'b0);
    swap = 1'b1;
    cyc();
    swap      = 1'b0;
    out_ready = 1'b1;
    beats     = 0;
    for (int c = 0; c < 50 && beats < 4; c++) begin
      if (out_valid) beats++;
      if (beats < 4) cyc();
    end
    chki("midrst beats", beats, 4);
    reset = 1'b0;
    #1;
    chkb("midrst async valid", out_valid, 1'b0);
    chkb("midrst async busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chkb("midrst busy", busy, 1'b0);
    chkb("midrst fill_bank", fill_bank, 1'b0);
    chkb("midrst swap_ready", swap_ready, 1'b1);
    cyc();
    chkb("midrst no resume", out_valid, 1'b0);
    out_ready = 1'b0;

    for (int a = 0; a < 5; a++) wr(a, 16'(a + 1), 1'b0, 1'b0);
    wr(5, 16'h000A, 1'b0, 1'b0);
    wr(6, 16'h7FFF, 1'b0, 1'b0);
`ifdef PSUM_ACC_EN
    wr(6, 16'h0001, 1'b1, 1'b0);
    wr(5, 16'h0001, 1'b1, 1'b0);
    wr(5, 16'h0001, 1'b1, 1'b0);
    wr(5, 16'h0001, 1'b1, 1'b1);
    exq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd13, 16'h8000};
`else
    wr(5, 16'h0001, 1'b1, 1'b1);
    exq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd1, 16'h7FFF};
`endif
    drain("acc", 1'b0, 1'b0);
    chkb("acc busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
